seg_to_bin: RTL and testbench
=============================

SEG_TO_BIN -- requirements
Module: seg_to_bin

Interface
REQ-001 Parameter: none; the block SHALL be fixed-width (two display digits, 7-bit binary result).
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on the rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port seg1, input, 7 bits: tens-digit segment pattern, bit order g f e d c b a, active-low.
REQ-005 Port seg0, input, 7 bits: units-digit segment pattern, same ordering and polarity.
REQ-006 Port start, input, 1 bit: request a conversion; sampled only in IDLE.
REQ-007 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-008 Port done, output, 1 bit: one-cycle pulse marking the end of a conversion.
REQ-009 Port err, output, 1 bit: the last conversion had an unrecognised segment pattern.
REQ-010 Port bin, output, 7 bits: binary value of the displayed two-digit decimal number, 0..99.

Function
REQ-011 The legal patterns SHALL be exactly: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-012 States SHALL be IDLE, SHIFT and DONE.
REQ-013 IDLE: start=1 SHALL latch both digits, each segment pattern decoded to 4-bit BCD, into an 8-bit BCD register, and SHALL clear the 3-bit shift counter.
REQ-014 IDLE: if both patterns are legal, the next state SHALL be SHIFT; otherwise the next state SHALL be DONE with err=1 and bin=0.
REQ-015 SHIFT (reverse double-dabble): each cycle, shift {bcd, acc} right by 1 bit; then, for each BCD nibble that is >= 8, subtract 3 from that nibble.
REQ-016 SHIFT SHALL last exactly 8 cycles; on the 8th cycle, acc[7:1] SHALL be loaded to bin, err SHALL be cleared, and the next state SHALL be DONE.
REQ-017 Latency: with start sampled high in cycle n, done SHALL be high in cycle n+9 for a valid conversion, and in cycle n+1 for an invalid one.
REQ-018 DONE SHALL last one cycle with done=1, and the next state SHALL be IDLE.
REQ-019 start while busy=1 SHALL be ignored, and SHALL NOT be queued.
REQ-020 bin and err SHALL hold their values from the end of a conversion until the next DONE.
REQ-021 seg1 and seg0 changing after acceptance SHALL NOT affect the conversion in progress.
REQ-022 start held high continuously SHALL begin a new conversion in each IDLE cycle, that is, every 10 cycles for valid input.

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE and clear busy, done, err, bin, the counter and all internal registers, with priority over every other event.
REQ-024 rst asserted during SHIFT or DONE SHALL abort the conversion, and no done pulse SHALL follow.
REQ-025 In the cycle after rst deasserts, start SHALL be accepted normally.

Configuration
REQ-026 Macro BLANK_TENS_EN defined: seg1=1111111 (blank) SHALL be accepted as tens digit 0.
REQ-027 Macro BLANK_TENS_EN undefined: seg1=1111111 SHALL be illegal and SHALL set err.
REQ-028 seg0=1111111 SHALL be illegal in both builds.

Verification
REQ-029 seg1=1000000, seg0=1000000, start pulse: bin=0, err=0, done in cycle n+9.
REQ-030 seg1=0010000 (9), seg0=0010000 (9): bin=99 (1100011), err=0; also check 4/2 -> bin=42.
REQ-031 seg0=1111111 or seg1=0101010: done in cycle n+1, err=1, bin=0; a following valid 1/5 -> bin=15, err=0.
REQ-032 start pulsed in cycles n+3 and n+9 of a conversion: no extra conversion, exactly one done.
REQ-033 rst pulsed in cycle n+4: busy=0 next cycle, no done, bin=0; the next start converts normally.
REQ-034 seg1=1111111, seg0=0000010: bin=6, err=0 with BLANK_TENS_EN; err=1, bin=0 without it.

Source files
------------

// File: rtl/seg_to_bin.sv
// seg_to_bin: converts two active-low 7-segment digits (g..a) to a 7-bit binary value via reverse double-dabble.
// Ports: clk, rst (sync, active-high); seg1/seg0 tens/units patterns; start request;
//        busy (not IDLE), done (one-cycle pulse), err (last pattern illegal), bin (0..99).
// Define BLANK_TENS_EN to accept a blank tens digit (1111111) as 0.
module seg_to_bin (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg1,
  input  logic [6:0] seg0,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [6:0] bin
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] bcd_q, bcd_d, acc_q, acc_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] bin_q, bin_d;
  logic err_q, err_d;
  logic [4:0] tens, units;
  logic [15:0] sh;
  // Returns {legal, bcd}.
  function automatic logic [4:0] dec(input logic [6:0] s);
    case (s)
      7'b1000000: dec = 5'h10;
      7'b1111001: dec = 5'h11;
      7'b0100100: dec = 5'h12;
      7'b0110000: dec = 5'h13;
      7'b0011001: dec = 5'h14;
      7'b0010010: dec = 5'h15;
      7'b0000010: dec = 5'h16;
      7'b1111000: dec = 5'h17;
      7'b0000000: dec = 5'h18;
      7'b0010000: dec = 5'h19;
      default:    dec = 5'h00;
    endcase
  endfunction
`ifdef BLANK_TENS_EN
  assign tens = (seg1 == 7'h7f) ? 5'h10 : dec(seg1);
`else
  assign tens = dec(seg1);
`endif
  assign units = dec(seg0);
  assign sh = {bcd_q, acc_q} >> 1;
  always_comb begin
    state_d = state_q;
    bcd_d = bcd_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        bcd_d = {tens[3:0], units[3:0]};
        acc_d = '0;
        cnt_d = '0;
        state_d = (tens[4] && units[4]) ? SHIFT : DONE;
        if (!(tens[4] && units[4])) begin
          err_d = 1'b1;
          bin_d = '0;
        end
      end
      SHIFT: begin
        bcd_d[7:4] = (sh[15:12] >= 4'd8) ? sh[15:12] - 4'd3 : sh[15:12];
        bcd_d[3:0] = (sh[11:8] >= 4'd8) ? sh[11:8] - 4'd3 : sh[11:8];
        acc_d = sh[7:0];
        cnt_d = cnt_q + 3'd1;
        // After seven shifts the low binary bits sit in acc_q[7:1]; the eighth shift only fills the pipeline.
        if (cnt_q == 3'd7) begin
          bin_d = acc_q[7:1];
          err_d = 1'b0;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcd_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bcd_q <= bcd_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      err_q <= err_d;
    end
  end
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err = err_q;
  assign bin = bin_q;
endmodule

// File: tb/tb_seg_to_bin.sv
// tb_seg_to_bin: directed and randomized checks of seg_to_bin against a digit-table reference model.
module tb_seg_to_bin;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [6:0] seg1 = 7'h7f, seg0 = 7'h7f;
  logic busy, done, err;
  logic [6:0] bin;
  int errors = 0, checks = 0;
  logic [6:0] pat [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
`ifdef BLANK_TENS_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  always #5 clk = ~clk;
  seg_to_bin dut (.clk(clk), .rst(rst), .seg1(seg1), .seg0(seg0), .start(start),
                  .busy(busy), .done(done), .err(err), .bin(bin));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic int dig(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (p == pat[i]) return i;
    return -1;
  endfunction
  task automatic convert(input logic [6:0] s1, input logic [6:0] s0, input string tag);
    int t, u, k, eb;
    bit ok;
    t = (s1 == 7'h7f && BLANK) ? 0 : dig(s1);
    u = dig(s0);
    ok = (t >= 0) && (u >= 0);
    eb = ok ? 10 * t + u : 0;
    seg1 = s1;
    seg0 = s0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seg1 = 7'($urandom);
    seg0 = 7'($urandom);
    chk({tag, " busy"}, 32'(busy), 1);
    k = 1;
    while (!done && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " latency"}, k, ok ? 9 : 1);
    chk({tag, " err"}, 32'(err), 32'(!ok));
    chk({tag, " bin"}, 32'(bin), eb);
    @(posedge clk); #1;
    chk({tag, " done_low"}, 32'(done), 0);
    chk({tag, " idle"}, 32'(busy), 0);
    chk({tag, " bin_hold"}, 32'(bin), eb);
  endtask
  initial begin
    int d1, d2, nd, dc;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst err", 32'(err), 0);
    chk("rst bin", 32'(bin), 0);
    rst = 1'b0;
    convert(pat[0], pat[0], "zero");
    convert(pat[9], pat[9], "ninety_nine");
    convert(pat[4], pat[2], "forty_two");
    convert(pat[3], 7'h7f, "blank_units");
    convert(7'b0101010, pat[1], "bad_tens");
    convert(pat[1], pat[5], "fifteen");
    convert(7'h7f, pat[6], "blank_tens");
    convert(7'h7f, 7'h7f, "both_blank");
    seg1 = pat[6];
    seg0 = pat[1];
    start = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    dc = -1;
    for (int c = 1; c <= 14; c++) begin
      start = (c == 3 || c == 9);
      if (done) begin
        nd++;
        dc = c;
      end
      if (c >= 10) chk("ignored_start idle", 32'(busy), 0);
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("ignored_start done_count", nd, 1);
    chk("ignored_start done_cycle", dc, 9);
    chk("ignored_start bin", 32'(bin), 61);
    convert(pat[7], pat[3], "pre_abort");
    seg1 = pat[2];
    seg0 = pat[8];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort bin", 32'(bin), 0);
    chk("abort err", 32'(err), 0);
    convert(pat[3], pat[8], "after_abort");
    for (int r = 0; r < 30; r++) begin
      logic [6:0] a, b;
      a = ($urandom_range(5) == 0) ? 7'($urandom) : pat[$urandom_range(9)];
      b = ($urandom_range(5) == 0) ? 7'($urandom) : pat[$urandom_range(9)];
      convert(a, b, "random");
    end
    seg1 = pat[5];
    seg0 = pat[7];
    start = 1'b1;
    d1 = -1;
    d2 = -1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    start = 1'b0;
    chk("held_start period", d2 - d1, 10);
    chk("held_start bin", 32'(bin), 57);
    repeat (12) @(posedge clk);
    #1;
    chk("final idle", 32'(busy), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
